// File: rtl/axi_lite_slave_mem.sv
// AXI4-Lite slave with a word-addressed internal memory; independent single-outstanding write and read paths.
// Build option AXI_SLAVE_MEM_RANGE_ERR_EN: out-of-range accesses answer SLVERR instead of wrapping.
//
// state  | meaning
// W_IDLE | collecting AW and W (either order), commit once both are held
// W_RESP | BVALID asserted, waiting for BREADY
// R_IDLE | ARREADY asserted, waiting for an address
// R_DATA | RVALID/RLAST asserted, waiting for RREADY
module axi_lite_slave_mem #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16
) (
  input  logic                      ACLK,
  input  logic                      ARESETn,
  input  logic                      S_AXI_AWVALID,
  output logic                      S_AXI_AWREADY,
  input  logic [ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [7:0]                S_AXI_AWPROT,
  input  logic                      S_AXI_WVALID,
  output logic                      S_AXI_WREADY,
  input  logic [DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                      S_AXI_WLAST,
  output logic                      S_AXI_BVALID,
  input  logic                      S_AXI_BREADY,
  output logic [1:0]                S_AXI_BRESP,
  input  logic                      S_AXI_ARVALID,
  output logic                      S_AXI_ARREADY,
  input  logic [ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [7:0]                S_AXI_ARPROT,
  output logic                      S_AXI_RVALID,
  input  logic                      S_AXI_RREADY,
  output logic [DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                S_AXI_RRESP,
  output logic                      S_AXI_RLAST
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFS    = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(DEPTH);

  typedef enum logic { W_IDLE, W_RESP } w_state_e;
  typedef enum logic { R_IDLE, R_DATA } r_state_e;

  w_state_e                w_state_q;
  logic                    aw_rdy_q, w_rdy_q, aw_held_q, w_held_q;
  logic [ADDR_WIDTH-1:0]   awaddr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [STRB_W-1:0]       wstrb_q;
  logic                    bvalid_q;
  logic [1:0]              bresp_q;

  r_state_e                r_state_q;
  logic                    ar_rdy_q, rvalid_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic [1:0]              rresp_q;

  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic                    aw_hs, w_hs, ar_hs, aw_have_d, w_have_d, commit_d;
  logic [ADDR_WIDTH-1:0]   wr_addr_d;
  logic [DATA_WIDTH-1:0]   wr_data_d;
  logic [STRB_W-1:0]       wr_strb_d;
  logic [IDX_W-1:0]        wr_idx_d, rd_idx_d;
  logic                    wr_err_d, rd_err_d;

  function automatic logic out_of_range(input logic [ADDR_WIDTH-1:0] a);
    return (a >> (OFS + IDX_W)) != '0;
  endfunction

  assign aw_hs     = S_AXI_AWVALID & aw_rdy_q;
  assign w_hs      = S_AXI_WVALID & w_rdy_q;
  assign ar_hs     = S_AXI_ARVALID & ar_rdy_q;
  assign aw_have_d = aw_held_q | aw_hs;
  assign w_have_d  = w_held_q | w_hs;
  assign commit_d  = (w_state_q == W_IDLE) & aw_have_d & w_have_d;

  // Address/data come from the latch if captured earlier, else straight from the bus this cycle.
  assign wr_addr_d = aw_held_q ? awaddr_q : S_AXI_AWADDR;
  assign wr_data_d = w_held_q ? wdata_q : S_AXI_WDATA;
  assign wr_strb_d = w_held_q ? wstrb_q : S_AXI_WSTRB;
  assign wr_idx_d  = wr_addr_d[OFS +: IDX_W];
  assign rd_idx_d  = S_AXI_ARADDR[OFS +: IDX_W];

`ifdef AXI_SLAVE_MEM_RANGE_ERR_EN
  assign wr_err_d = out_of_range(wr_addr_d);
  assign rd_err_d = out_of_range(S_AXI_ARADDR);
`else
  assign wr_err_d = 1'b0;
  assign rd_err_d = 1'b0;
`endif

  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_WLAST, wr_addr_d, S_AXI_ARADDR};

  always_ff @(posedge ACLK) begin
    if (commit_d && !wr_err_d) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wr_strb_d[b]) mem_q[wr_idx_d][8*b +: 8] <= wr_data_d[8*b +: 8];
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      w_state_q <= W_IDLE;
      aw_rdy_q  <= 1'b0;
      w_rdy_q   <= 1'b0;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
    end else begin
      case (w_state_q)
        W_IDLE: begin
          if (commit_d) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            aw_rdy_q  <= 1'b0;
            w_rdy_q   <= 1'b0;
            bvalid_q  <= 1'b1;
            bresp_q   <= wr_err_d ? 2'b10 : 2'b00;
            w_state_q <= W_RESP;
          end else begin
            aw_held_q <= aw_have_d;
            w_held_q  <= w_have_d;
            aw_rdy_q  <= ~aw_have_d;
            w_rdy_q   <= ~w_have_d;
            if (aw_hs) awaddr_q <= S_AXI_AWADDR;
            if (w_hs) begin
              wdata_q <= S_AXI_WDATA;
              wstrb_q <= S_AXI_WSTRB;
            end
          end
        end
        W_RESP: begin
          if (S_AXI_BREADY) begin
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            aw_rdy_q  <= 1'b1;
            w_rdy_q   <= 1'b1;
            w_state_q <= W_IDLE;
          end
        end
      endcase
    end
  end

  // Read samples mem_q before any same-edge commit lands, so a colliding read returns old data.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state_q <= R_IDLE;
      ar_rdy_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= 2'b00;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          if (ar_hs) begin
            rdata_q   <= rd_err_d ? '0 : mem_q[rd_idx_d];
            rresp_q   <= rd_err_d ? 2'b10 : 2'b00;
            rvalid_q  <= 1'b1;
            ar_rdy_q  <= 1'b0;
            r_state_q <= R_DATA;
          end else begin
            ar_rdy_q <= 1'b1;
          end
        end
        R_DATA: begin
          if (S_AXI_RREADY) begin
            rvalid_q  <= 1'b0;
            ar_rdy_q  <= 1'b1;
            r_state_q <= R_IDLE;
          end
        end
      endcase
    end
  end

  assign S_AXI_AWREADY = aw_rdy_q;
  assign S_AXI_WREADY  = w_rdy_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = ar_rdy_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RLAST   = rvalid_q;

endmodule

// File: tb/tb_axi_lite_slave_mem.sv
// Bench for axi_lite_slave_mem: table of write/readback vectors, hand sequences for ordering,
// backpressure, collision, range and reset; read data checked through an expectation queue.
module tb_axi_lite_slave_mem;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic        AWVALID = 0, AWREADY, WVALID = 0, WREADY, WLAST = 1;
  logic [31:0] AWADDR = 0, WDATA = 0, ARADDR = 0, RDATA;
  logic [7:0]  AWPROT = 0, ARPROT = 0;
  logic [3:0]  WSTRB = 0;
  logic        BVALID, BREADY = 1, ARVALID = 0, ARREADY, RVALID, RREADY = 1, RLAST;
  logic [1:0]  BRESP, RRESP;

  int total = 0;
  int bad = 0;
  logic [33:0] exp_q[$];

  always #5 ACLK = ~ACLK;

  axi_lite_slave_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(16)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .S_AXI_AWVALID(AWVALID), .S_AXI_AWREADY(AWREADY), .S_AXI_AWADDR(AWADDR), .S_AXI_AWPROT(AWPROT),
    .S_AXI_WVALID(WVALID), .S_AXI_WREADY(WREADY), .S_AXI_WDATA(WDATA), .S_AXI_WSTRB(WSTRB),
    .S_AXI_WLAST(WLAST), .S_AXI_BVALID(BVALID), .S_AXI_BREADY(BREADY), .S_AXI_BRESP(BRESP),
    .S_AXI_ARVALID(ARVALID), .S_AXI_ARREADY(ARREADY), .S_AXI_ARADDR(ARADDR), .S_AXI_ARPROT(ARPROT),
    .S_AXI_RVALID(RVALID), .S_AXI_RREADY(RREADY), .S_AXI_RDATA(RDATA), .S_AXI_RRESP(RRESP),
    .S_AXI_RLAST(RLAST)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge ACLK) begin
    if (ARESETn && RVALID && RREADY) begin
      if (exp_q.size() == 0) begin
        chk("r_unexpected_beat", 64'(RVALID), 64'd0);
      end else begin
        logic [33:0] e;
        e = exp_q.pop_front();
        chk("r_data", 64'(RDATA), 64'(e[31:0]));
        chk("r_resp", 64'(RRESP), 64'(e[33:32]));
        chk("r_last", 64'(RLAST), 64'd1);
      end
    end
  end

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                    input logic [1:0] resp, input string nm);
    bit ok;
    @(posedge ACLK); #1;
    AWADDR = a; WDATA = d; WSTRB = s; AWVALID = 1; WVALID = 1; BREADY = 1;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge ACLK);
      if (AWREADY && WREADY) ok = 1;
      else @(posedge ACLK);
    end
    chk({nm, "_ready"}, 64'(ok), 64'd1);
    @(posedge ACLK); #1;
    AWVALID = 0; WVALID = 0;
    @(negedge ACLK);
    chk({nm, "_bvalid"}, 64'(BVALID), 64'd1);
    chk({nm, "_bresp"}, 64'(BRESP), 64'(resp));
    @(posedge ACLK); #1;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] d, input logic [1:0] resp,
                    input string nm);
    bit ok;
    @(posedge ACLK); #1;
    ARADDR = a; ARVALID = 1; RREADY = 1;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge ACLK);
      if (ARREADY) ok = 1;
      else @(posedge ACLK);
    end
    chk({nm, "_arready"}, 64'(ok), 64'd1);
    exp_q.push_back({resp, d});
    @(posedge ACLK); #1;
    ARVALID = 0;
    @(negedge ACLK);
    chk({nm, "_rvalid"}, 64'(RVALID), 64'd1);
    @(posedge ACLK); #1;
  endtask

  typedef struct {
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] raddr;
    logic [31:0] rexp;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'h08, 32'hDEADBEEF, 4'hF, 32'h08, 32'hDEADBEEF};
    vecs[1] = '{32'h04, 32'hAAAAAAAA, 4'hF, 32'h04, 32'hAAAAAAAA};
    vecs[2] = '{32'h0C, 32'h00000000, 4'hF, 32'h0C, 32'h00000000};
    vecs[3] = '{32'h10, 32'hCAFEF00D, 4'hF, 32'h10, 32'hCAFEF00D};
    vecs[4] = '{32'h10, 32'h12345678, 4'h0, 32'h10, 32'hCAFEF00D};
    vecs[5] = '{32'h3F, 32'h0F0F0F0F, 4'hF, 32'h3C, 32'h0F0F0F0F};

    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    chk("rst_awready", 64'(AWREADY), 64'd0);
    chk("rst_wready", 64'(WREADY), 64'd0);
    chk("rst_arready", 64'(ARREADY), 64'd0);
    chk("rst_bvalid", 64'(BVALID), 64'd0);
    chk("rst_rvalid", 64'(RVALID), 64'd0);
    chk("rst_rdata", 64'(RDATA), 64'd0);
    #2 ARESETn = 1;
    @(posedge ACLK); @(negedge ACLK);
    chk("post_rst_awready", 64'(AWREADY), 64'd1);

    for (int i = 0; i < 6; i++) begin
      wr(vecs[i].waddr, vecs[i].wdata, vecs[i].wstrb, 2'b00, $sformatf("vec%0d_wr", i));
      rd(vecs[i].raddr, vecs[i].rexp, 2'b00, $sformatf("vec%0d_rd", i));
    end
    wr(32'h10, 32'h12345678, 4'b1010, 2'b00, "strb_mix_wr");
    rd(32'h10, 32'h12FE560D, 2'b00, "strb_mix_rd");

    // W leads AW by three cycles
    @(posedge ACLK); #1;
    WDATA = 32'h11223344; WSTRB = 4'h3; WVALID = 1; BREADY = 1;
    @(negedge ACLK);
    chk("t2_wready_pre", 64'(WREADY), 64'd1);
    @(posedge ACLK); #1;
    WVALID = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge ACLK);
      chk("t2_wready_low", 64'(WREADY), 64'd0);
      chk("t2_awready_high", 64'(AWREADY), 64'd1);
      chk("t2_no_bvalid", 64'(BVALID), 64'd0);
      @(posedge ACLK);
    end
    #1 AWADDR = 32'h04; AWVALID = 1;
    @(negedge ACLK);
    chk("t2_awready", 64'(AWREADY), 64'd1);
    @(posedge ACLK); #1;
    AWVALID = 0;
    @(negedge ACLK);
    chk("t2_bvalid", 64'(BVALID), 64'd1);
    @(posedge ACLK); #1;
    rd(32'h04, 32'hAAAA3344, 2'b00, "t2_rd");

    // B backpressure with a new AW+W waiting
    @(posedge ACLK); #1;
    AWADDR = 32'h14; WDATA = 32'h77; WSTRB = 4'hF; AWVALID = 1; WVALID = 1; BREADY = 0;
    @(negedge ACLK);
    chk("t3_ready", 64'(AWREADY & WREADY), 64'd1);
    @(posedge ACLK); #1;
    AWADDR = 32'h18; WDATA = 32'h99;
    for (int i = 0; i < 5; i++) begin
      @(negedge ACLK);
      chk("t3_bvalid_hold", 64'(BVALID), 64'd1);
      chk("t3_bresp_hold", 64'(BRESP), 64'd0);
      chk("t3_awready_low", 64'(AWREADY), 64'd0);
      chk("t3_wready_low", 64'(WREADY), 64'd0);
    end
    @(posedge ACLK); #1;
    BREADY = 1;
    @(posedge ACLK);
    @(negedge ACLK);
    chk("t3_bvalid_drop", 64'(BVALID), 64'd0);
    chk("t3_awready_back", 64'(AWREADY), 64'd1);
    chk("t3_wready_back", 64'(WREADY), 64'd1);
    @(posedge ACLK); #1;
    AWVALID = 0; WVALID = 0;
    @(negedge ACLK);
    chk("t3_second_bvalid", 64'(BVALID), 64'd1);
    @(posedge ACLK); #1;
    rd(32'h14, 32'h77, 2'b00, "t3_rd14");
    rd(32'h18, 32'h99, 2'b00, "t3_rd18");

    // Commit and read of the same word on one edge
    @(posedge ACLK); #1;
    AWADDR = 32'h0C; WDATA = 32'h5; WSTRB = 4'hF; AWVALID = 1; WVALID = 1;
    ARADDR = 32'h0C; ARVALID = 1; BREADY = 1; RREADY = 1;
    @(negedge ACLK);
    chk("t4_ready", 64'(AWREADY & WREADY & ARREADY), 64'd1);
    exp_q.push_back({2'b00, 32'h0});
    @(posedge ACLK); #1;
    AWVALID = 0; WVALID = 0; ARVALID = 0;
    @(negedge ACLK);
    chk("t4_bvalid", 64'(BVALID), 64'd1);
    chk("t4_rvalid", 64'(RVALID), 64'd1);
    @(posedge ACLK); #1;
    rd(32'h0C, 32'h5, 2'b00, "t4_rd_new");

    // Out-of-range address 0x44 (word 1 holds 0xAAAA3344)
`ifdef AXI_SLAVE_MEM_RANGE_ERR_EN
    wr(32'h44, 32'h55667788, 4'hF, 2'b10, "t5_wr");
    rd(32'h04, 32'hAAAA3344, 2'b00, "t5_rd_word1");
    rd(32'h44, 32'h0, 2'b10, "t5_rd_oor");
`else
    wr(32'h44, 32'h55667788, 4'hF, 2'b00, "t5_wr");
    rd(32'h04, 32'h55667788, 2'b00, "t5_rd_word1");
    rd(32'h44, 32'h55667788, 2'b00, "t5_rd_alias");
`endif

    // Reset while both responses are pending
    @(posedge ACLK); #1;
    AWADDR = 32'h20; WDATA = 32'h1234; WSTRB = 4'hF; AWVALID = 1; WVALID = 1; BREADY = 0;
    ARADDR = 32'h08; ARVALID = 1; RREADY = 0;
    @(negedge ACLK);
    @(posedge ACLK); #1;
    AWVALID = 0; WVALID = 0; ARVALID = 0;
    @(negedge ACLK);
    chk("t6_bvalid_pre", 64'(BVALID), 64'd1);
    chk("t6_rvalid_pre", 64'(RVALID), 64'd1);
    #2 ARESETn = 0;
    #1;
    chk("t6_bvalid_rst", 64'(BVALID), 64'd0);
    chk("t6_rvalid_rst", 64'(RVALID), 64'd0);
    chk("t6_rlast_rst", 64'(RLAST), 64'd0);
    chk("t6_rdata_rst", 64'(RDATA), 64'd0);
    chk("t6_awready_rst", 64'(AWREADY), 64'd0);
    @(posedge ACLK); #1;
    ARESETn = 1; BREADY = 1; RREADY = 1;
    @(posedge ACLK);
    @(negedge ACLK);
    chk("t6_awready", 64'(AWREADY), 64'd1);
    chk("t6_wready", 64'(WREADY), 64'd1);
    chk("t6_arready", 64'(ARREADY), 64'd1);
    rd(32'h08, 32'hDEADBEEF, 2'b00, "t6_rd08");
    rd(32'h20, 32'h1234, 2'b00, "t6_rd20");

    repeat (3) @(posedge ACLK);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_lite_slave_mem.md
Name: axi_lite_slave_mem

Overview:
- AXI4-Lite slave responder with a word-addressed internal memory.
- Attaches to the M_AXI_* side of the DUT in the testbench and answers the transactions the DUT issues downstream.
- Uses the same channel set and widths as the bench AXI interface.
- Single-beat transfers only; at most one write and one read outstanding, with the write and read paths independent.

Parameters:
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width; must be 32 or 64.
- DEPTH, 16, number of DATA_WIDTH words; must be a power of 2.

Ports:
- ACLK  in  1  clock.
- ARESETn  in  1  asynchronous active-low reset.
- S_AXI_AWVALID  in  1  write address valid.
- S_AXI_AWREADY  out  1  write address ready.
- S_AXI_AWADDR  in  ADDR_WIDTH  write byte address.
- S_AXI_AWPROT  in  8  ignored.
- S_AXI_WVALID  in  1  write data valid.
- S_AXI_WREADY  out  1  write data ready.
- S_AXI_WDATA  in  DATA_WIDTH  write data.
- S_AXI_WSTRB  in  DATA_WIDTH/8  byte strobes.
- S_AXI_WLAST  in  1  ignored.
- S_AXI_BVALID  out  1  write response valid.
- S_AXI_BREADY  in  1  write response ready.
- S_AXI_BRESP  out  2  write response.
- S_AXI_ARVALID  in  1  read address valid.
- S_AXI_ARREADY  out  1  read address ready.
- S_AXI_ARADDR  in  ADDR_WIDTH  read byte address.
- S_AXI_ARPROT  in  8  ignored.
- S_AXI_RVALID  out  1  read data valid.
- S_AXI_RREADY  in  1  read data ready.
- S_AXI_RDATA  out  DATA_WIDTH  read data.
- S_AXI_RRESP  out  2  read response.
- S_AXI_RLAST  out  1  last beat; always 1 while RVALID.

Behaviour:
- Clock and reset: one clock ACLK; ARESETn asynchronous, active-low.
- Reset values (asserted, any cycle including mid-transaction): all READY, BVALID, RVALID, RLAST = 0; BRESP, RRESP = 2'b00; RDATA = 0; internal FSMs return to IDLE.
  - Memory array is not reset.
  - A pending write not yet committed is discarded.
- Word index: idx = addr[OFS +: log2(DEPTH)], where OFS = log2(DATA_WIDTH/8). Address bits below OFS are ignored.
- Write FSM states: W_IDLE, W_RESP.
  - W_IDLE: AWREADY = 1 until AW is captured; WREADY = 1 until W is captured. AW and W may arrive in either order or in the same cycle, and each is latched on its own handshake.
  - Commit: on the edge where both AW and W are held (latched or handshaking that cycle), the memory word is written per WSTRB, BVALID is set at that edge, and the FSM moves to W_RESP.
  - Latency: same-cycle AW+W gives BVALID on the next cycle.
  - W_RESP: AWREADY = WREADY = 0; BVALID held with stable BRESP until BREADY. On handshake, BVALID drops and the FSM returns to W_IDLE with AWREADY = WREADY = 1 the next cycle.
  - WSTRB = 0: OKAY response, memory unchanged.
- Read FSM states: R_IDLE, R_DATA.
  - R_IDLE: ARREADY = 1. On AR handshake, RDATA <= mem[idx], RVALID = RLAST = 1, and the FSM moves to R_DATA (one-cycle latency).
  - R_DATA: ARREADY = 0; RDATA, RRESP, RVALID held until RREADY. On handshake, RVALID = RLAST = 0 and ARREADY = 1 the next cycle.
- Simultaneous write commit and AR handshake to the same word: the read returns pre-write data.
- Out-of-range address (addr >= DEPTH*DATA_WIDTH/8), without the optional feature: upper bits are ignored (wrap) and the response is OKAY.

Optional Feature:
- Macro: AXI_SLAVE_MEM_RANGE_ERR_EN.
- Defined:
  - Out-of-range write: memory untouched, BRESP = 2'b10 (SLVERR).
  - Out-of-range read: RDATA = 0, RRESP = 2'b10.
  - Same latency and handshakes as in-range accesses.
- Undefined: address wraps per idx, response always OKAY.

Test Plan:
1. AW=0x08, W=0xDEADBEEF, WSTRB=0xF in the same cycle, BREADY=1 -> BVALID the next cycle, BRESP=0. Then AR=0x08 -> RVALID 1 cycle later, RDATA=0xDEADBEEF, RLAST=1, RRESP=0.
2. W issued 3 cycles before AW (addr 0x04, data 0x11223344, WSTRB=0x3) over prior contents 0xAAAAAAAA -> WREADY drops after the W handshake; read of 0x04 returns 0xAAAA3344.
3. BREADY held low for 5 cycles -> BVALID and BRESP stable, AWREADY=WREADY=0 throughout; a new AW is accepted only after the B handshake.
4. Write 0x5 to 0x0C committing on the same edge as AR=0x0C (old value 0x0) -> RDATA=0x0; a later read returns 0x5.
5. DEPTH=16: access address 0x44.
   - Macro off: aliases word 1, OKAY.
   - Macro on: write gives BRESP=2'b10 with word 1 unchanged; read gives RDATA=0, RRESP=2'b10.
6. ARESETn pulsed low while RVALID=1 and BVALID=1 -> both drop immediately; after release, AWREADY=WREADY=ARREADY=1; memory contents retained.
